// File: rtl/f1_reaction_timer.sv
// F1 start-light reaction timer: detects lights-out, counts ticks to the trigger press, flags false starts.
// Outputs decode from the state register (visible the cycle after the deciding edge); no backpressure; F1_BEST_TIME_EN adds best_time.
module f1_reaction_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           lights_in,
  input  logic                 trigger,
  input  logic                 tick,
  output logic [CNT_WIDTH-1:0] react_time,
  output logic                 valid,
  output logic                 false_start,
  output logic                 busy
`ifdef F1_BEST_TIME_EN
  ,
  output logic [CNT_WIDTH-1:0] best_time
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    ALL_ON = 3'd2,
    TIMING = 3'd3,
    DONE   = 3'd4,
    FOUL   = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] counter_nxt;
  logic                 trig_q;
  logic                 press;
  logic                 capture;

  // A held button yields exactly one press on its rising edge.
  assign press = trigger & ~trig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      react_time <= '0;
      trig_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      trig_q  <= trigger;
      if (capture) begin
        react_time <= counter;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    capture     = 1'b0;
    valid       = 1'b0;
    false_start = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (lights_in != 8'h00) state_nxt = ARMED;
      end
      ARMED: begin
        busy = 1'b1;
        if (press)                   state_nxt = FOUL;
        else if (lights_in == 8'hFF) state_nxt = ALL_ON;
        else if (lights_in == 8'h00) state_nxt = IDLE;
      end
      ALL_ON: begin
        busy = 1'b1;
        // Press wins over a simultaneous lights-out.
        if (press) begin
          state_nxt = FOUL;
        end else if (lights_in == 8'h00) begin
          state_nxt   = TIMING;
          counter_nxt = '0;
        end
      end
      TIMING: begin
        busy = 1'b1;
        if (press) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else if (tick && (counter != CNT_MAX)) begin
          counter_nxt = counter + CNT_ONE;
        end
      end
      DONE: begin
        valid = 1'b1;
        if (lights_in != 8'h00) state_nxt = ARMED;
      end
      FOUL: begin
        false_start = 1'b1;
        if ((lights_in == 8'h00) && !trigger) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef F1_BEST_TIME_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      best_time <= '1;
    end else if (capture && (counter < best_time)) begin
      best_time <= counter;
    end
  end
`endif

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed bench for f1_reaction_timer; a second instance with CNT_WIDTH=4 shares stimulus to show saturation.
module tb_f1_reaction_timer;

  logic        clk;
  logic        rst;
  logic [7:0]  lights_in;
  logic        trigger;
  logic        tick;
  logic [15:0] react_time;
  logic        valid;
  logic        false_start;
  logic        busy;
  logic [3:0]  react_time4;
  logic        valid4;
  logic        false_start4;
  logic        busy4;
`ifdef F1_BEST_TIME_EN
  logic [15:0] best_time;
  logic [3:0]  best_time4;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  f1_reaction_timer #(.CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .lights_in   (lights_in),
    .trigger     (trigger),
    .tick        (tick),
    .react_time  (react_time),
    .valid       (valid),
    .false_start (false_start),
    .busy        (busy)
`ifdef F1_BEST_TIME_EN
    ,
    .best_time   (best_time)
`endif
  );

  f1_reaction_timer #(.CNT_WIDTH(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .lights_in   (lights_in),
    .trigger     (trigger),
    .tick        (tick),
    .react_time  (react_time4),
    .valid       (valid4),
    .false_start (false_start4),
    .busy        (busy4)
`ifdef F1_BEST_TIME_EN
    ,
    .best_time   (best_time4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs, let one rising edge sample them, then settle before checking.
  task automatic cyc(input logic [7:0] l, input logic t, input logic k);
    lights_in = l;
    trigger   = t;
    tick      = k;
    @(posedge clk);
    #1;
  endtask

  task automatic to_all_on(input logic t);
    logic [8:0] p;
    for (int i = 0; i < 8; i++) begin
      p = (9'd1 << (i + 1)) - 9'd1;
      for (int j = 0; j < 3; j++) cyc(p[7:0], t, 1'b0);
    end
  endtask

  task automatic to_timing(input logic t);
    to_all_on(t);
    cyc(8'h00, t, 1'b0);
  endtask

  task automatic run(input int n);
    to_timing(1'b0);
    for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("run_valid", 32'(valid), 32'd1);
    chk("run_react", 32'(react_time), 32'(n));
    cyc(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; lights_in = 8'h00; trigger = 1'b0; tick = 1'b0;

    // 1: reset, presses with lights off stay idle
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_react", 32'(react_time), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_fs", 32'(false_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cyc(8'h00, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b1, 1'b0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(valid), 32'd0);
    chk("idle_fs", 32'(false_start), 32'd0);
    cyc(8'h00, 1'b0, 1'b0);

    // 2: normal run, 37 ticks
    to_timing(1'b0);
    chk("timing_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 37; i++) cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("n_react", 32'(react_time), 32'd37);
    chk("n_valid", 32'(valid), 32'd1);
    chk("n_busy", 32'(busy), 32'd0);
    chk("n_fs", 32'(false_start), 32'd0);
    cyc(8'h00, 1'b0, 1'b0);
    chk("n_hold_valid", 32'(valid), 32'd1);

    // 3: false start, held trigger keeps foul, release returns idle
    cyc(8'h01, 1'b0, 1'b0);
    chk("rearm_valid", 32'(valid), 32'd0);
    chk("rearm_busy", 32'(busy), 32'd1);
    cyc(8'h03, 1'b0, 1'b0);
    cyc(8'h07, 1'b0, 1'b0);
    cyc(8'h0F, 1'b1, 1'b0);
    chk("fs_flag", 32'(false_start), 32'd1);
    chk("fs_valid", 32'(valid), 32'd0);
    chk("fs_react", 32'(react_time), 32'd37);
    chk("fs_busy", 32'(busy), 32'd0);
    cyc(8'h00, 1'b1, 1'b0);
    chk("fs_held", 32'(false_start), 32'd1);
    cyc(8'h00, 1'b0, 1'b0);
    chk("fs_release", 32'(false_start), 32'd0);
    chk("fs_rel_busy", 32'(busy), 32'd0);

    // 4: press coincident with lights-out is a foul
    to_all_on(1'b0);
    chk("allon_busy", 32'(busy), 32'd1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("coinc_fs", 32'(false_start), 32'd1);
    chk("coinc_busy", 32'(busy), 32'd0);
    chk("coinc_valid", 32'(valid), 32'd0);
    cyc(8'h00, 1'b0, 1'b0);
    chk("coinc_idle", 32'(false_start), 32'd0);

    // 5: saturation on the 4-bit instance, then held button across a whole run
    to_timing(1'b0);
    for (int i = 0; i < 20; i++) cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("sat16_react", 32'(react_time), 32'd20);
    chk("sat4_react", 32'(react_time4), 32'd15);
    chk("sat4_valid", 32'(valid4), 32'd1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("held_done", 32'(valid), 32'd1);
    to_timing(1'b1);
    chk("held_no_fs", 32'(false_start), 32'd0);
    chk("held_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) cyc(8'h00, 1'b1, 1'b1);
    chk("held_still_timing", 32'(busy), 32'd1);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("held_react", 32'(react_time), 32'd6);
    chk("held_react4", 32'(react_time4), 32'd6);
    chk("held_valid", 32'(valid), 32'd1);
    cyc(8'h00, 1'b0, 1'b0);

    // 6: reset during timing discards everything
    to_timing(1'b0);
    for (int i = 0; i < 10; i++) cyc(8'h00, 1'b0, 1'b1);
    rst = 1'b1;
    cyc(8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    chk("mrst_react", 32'(react_time), 32'd0);
    chk("mrst_valid", 32'(valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_fs", 32'(false_start), 32'd0);
    cyc(8'h00, 1'b1, 1'b0);
    chk("mrst_press_valid", 32'(valid), 32'd0);
    chk("mrst_press_fs", 32'(false_start), 32'd0);
    cyc(8'h00, 1'b0, 1'b0);
`ifdef F1_BEST_TIME_EN
    chk("best_rst", 32'(best_time), 32'hFFFF);
`endif
    run(37);
`ifdef F1_BEST_TIME_EN
    chk("best_1", 32'(best_time), 32'd37);
`endif
    run(25);
`ifdef F1_BEST_TIME_EN
    chk("best_2", 32'(best_time), 32'd25);
`endif
    run(40);
`ifdef F1_BEST_TIME_EN
    chk("best_3", 32'(best_time), 32'd25);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
